// File: rtl/s382_lamp_monitor.sv
// ============================================================================
// Module      : s382_lamp_monitor
// Description : Registers the s382 controller's six lamp outputs and forwards
//               them while legal. On the first violation it latches a fault
//               code and drives both reds, which flash when the optional
//               build macro LAMP_MON_FLASH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s382_lamp_monitor #(
    parameter int YMIN      = 3,
    parameter int TMAX      = 255,
    parameter int FLASH_DIV = 8,
    parameter int CW        = 8
) (
    input  logic       CK,
    input  logic       CLR,
    input  logic       GRN1,
    input  logic       YLW1,
    input  logic       RED1,
    input  logic       GRN2,
    input  logic       YLW2,
    input  logic       RED2,
    output logic       L_GRN1,
    output logic       L_YLW1,
    output logic       L_RED1,
    output logic       L_GRN2,
    output logic       L_YLW2,
    output logic       L_RED2,
    output logic       FAULT,
    output logic [2:0] FCODE
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLT   = 2'd2
    } state_t;

    localparam logic [CW-1:0] YMIN_C   = CW'(YMIN);
    localparam logic [CW-1:0] TMAX_C   = CW'(TMAX);
    localparam logic [5:0]    ALL_RED  = 6'b001_001;
    localparam logic [2:0]    HEAD_G   = 3'b100;
    localparam logic [2:0]    HEAD_Y   = 3'b010;
    localparam logic [2:0]    HEAD_R   = 3'b001;

    // Lamp vectors are packed {G1,Y1,R1,G2,Y2,R2}.
    state_t        state_q;
    logic [5:0]    s1_q;
    logic [5:0]    s2_q;
    logic [5:0]    lamp_q;
    logic          fault_q;
    logic [2:0]    fcode_q;
    logic [CW-1:0] wd_q,    wd_d;
    logic [CW-1:0] ycnt1_q, ycnt1_d;
    logic [CW-1:0] ycnt2_q, ycnt2_d;

    logic [5:0]    w_in;
    logic          w_run;
    logic          w_v1, w_v2, w_pv1, w_pv2;
    logic          w_chk1, w_chk2, w_chk3, w_chk4, w_chk5;
    logic [2:0]    w_code;

    function automatic logic head_ok(input logic [2:0] h);
        return (h == HEAD_G) || (h == HEAD_Y) || (h == HEAD_R);
    endfunction

    function automatic logic bad_step(input logic [2:0] prv, input logic [2:0] cur);
        return ((prv == HEAD_G) && (cur == HEAD_R)) ||
               ((prv == HEAD_Y) && (cur == HEAD_G)) ||
               ((prv == HEAD_R) && (cur == HEAD_Y));
    endfunction

    function automatic logic [CW-1:0] yel_next(input logic cur_y, input logic prv_y,
                                               input logic [CW-1:0] cnt);
        if (!cur_y)
            return '0;
        else if (!prv_y)
            return CW'(1);
        else if (cnt < YMIN_C)
            return cnt + 1'b1;
        else
            return cnt;
    endfunction

    assign w_in  = {GRN1, YLW1, RED1, GRN2, YLW2, RED2};
    assign w_run = (state_q == ST_RUN);

    always_comb begin
        w_v1   = head_ok(s1_q[5:3]);
        w_v2   = head_ok(s1_q[2:0]);
        w_pv1  = head_ok(s2_q[5:3]);
        w_pv2  = head_ok(s2_q[2:0]);
        w_chk1 = (s1_q[5] | s1_q[4]) & (s1_q[2] | s1_q[1]);
        w_chk2 = !w_v1 || !w_v2;
        // Counters hold the number of yellow cycles seen so far when yellow falls.
        w_chk3 = (s2_q[4] && !s1_q[4] && (ycnt1_q < YMIN_C)) ||
                 (s2_q[1] && !s1_q[1] && (ycnt2_q < YMIN_C));
        w_chk4 = w_v1 && w_v2 && w_pv1 && w_pv2 &&
                 (bad_step(s2_q[5:3], s1_q[5:3]) || bad_step(s2_q[2:0], s1_q[2:0]));
        w_chk5 = (wd_q == TMAX_C);

        w_code = 3'd0;
        if (w_chk1)
            w_code = 3'd1;
        else if (w_chk2 && w_run)
            w_code = 3'd2;
        else if (w_chk3 && w_run)
            w_code = 3'd3;
        else if (w_chk4 && w_run)
            w_code = 3'd4;
        else if (w_chk5)
            w_code = 3'd5;
    end

    always_comb begin
        wd_d    = (s1_q != s2_q) ? '0 : wd_q + 1'b1;
        ycnt1_d = yel_next(s1_q[4], s2_q[4], ycnt1_q);
        ycnt2_d = yel_next(s1_q[1], s2_q[1], ycnt2_q);
    end

`ifdef LAMP_MON_FLASH_EN
    // Compared one bit wider so 2*FLASH_DIV-1 is representable.
    localparam logic [CW:0]   FLASH_LAST = (CW+1)'(2 * FLASH_DIV - 1);
    localparam logic [CW-1:0] FLASH_HALF = CW'(FLASH_DIV);

    logic [CW-1:0] flash_q, flash_d;
    logic          w_red_on;

    always_comb begin
        flash_d  = ({1'b0, flash_q} == FLASH_LAST) ? '0 : flash_q + 1'b1;
        w_red_on = (flash_d < FLASH_HALF);
    end
`endif

    always_ff @(posedge CK) begin
        if (!CLR) begin
            state_q <= ST_START;
            s1_q    <= '0;
            s2_q    <= '0;
            lamp_q  <= ALL_RED;
            fault_q <= 1'b0;
            fcode_q <= 3'd0;
            wd_q    <= '0;
            ycnt1_q <= '0;
            ycnt2_q <= '0;
`ifdef LAMP_MON_FLASH_EN
            flash_q <= '0;
`endif
        end else if (state_q == ST_FLT) begin
`ifdef LAMP_MON_FLASH_EN
            flash_q   <= flash_d;
            lamp_q[3] <= w_red_on;
            lamp_q[0] <= w_red_on;
`endif
        end else begin
            s1_q    <= w_in;
            s2_q    <= s1_q;
            wd_q    <= wd_d;
            ycnt1_q <= ycnt1_d;
            ycnt2_q <= ycnt2_d;
            if (w_code != 3'd0) begin
                state_q <= ST_FLT;
                fault_q <= 1'b1;
                fcode_q <= w_code;
                lamp_q  <= ALL_RED;
`ifdef LAMP_MON_FLASH_EN
                flash_q <= '0;
`endif
            end else if (w_run || (w_v1 && w_v2)) begin
                // The entry edge already forwards s1 to keep one-cycle latency.
                state_q <= ST_RUN;
                lamp_q  <= s1_q;
            end
        end
    end

    assign {L_GRN1, L_YLW1, L_RED1, L_GRN2, L_YLW2, L_RED2} = lamp_q;
    assign FAULT = fault_q;
    assign FCODE = fcode_q;

endmodule

`default_nettype wire
